sr_latch_sequencer: RTL and testbench

Synthesizable initiator for the gated SR latch (`sr_latch`, ports S/R/E/Q/Qbar). It accepts set/reset/hold commands over a valid/ready handshake and drives S, R and E with a setup, pulse and hold sequence. It never drives S=R=1 and never changes S/R while E is high. An optional readback stage checks Q/Qbar after each command and reports the result with the `done` pulse.

---
 rtl/sr_latch_sequencer.sv | 214 +++++++++++++++++++++
 tb/tb_sr_latch_sequencer.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/sr_latch_sequencer.sv
// sr_latch_sequencer: valid/ready initiator for a gated SR latch.
// Drives S/R, then pulses E, then holds S/R, using setup/pulse/hold cycle counts.
// Optional readback (define SR_SEQ_READBACK_EN) checks Q/Qbar after each command
// and reports the result in err_code alongside the done pulse.
module sr_latch_sequencer #(
  parameter logic [7:0] SETUP_CYC = 8'd2,
  parameter logic [7:0] PULSE_CYC = 8'd3,
  parameter logic [7:0] HOLD_CYC  = 8'd1,
  parameter logic [7:0] CHK_CYC   = 8'd2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_valid,
  input  logic [1:0] req_op,
  output logic       req_ready,
  output logic       S,
  output logic       R,
  output logic       E,
  input  logic       Q,
  input  logic       Qbar,
  output logic       done,
  output logic [1:0] err_code
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_PULSE,
    ST_HOLD,
    ST_CHECK,
    ST_DONE
  } state_t;

  localparam logic [1:0] OP_SET   = 2'b10;
  localparam logic [1:0] OP_RESET = 2'b01;
  localparam logic [1:0] OP_ILL   = 2'b11;

  // Zero counts would collapse a phase; reject them at elaboration.
  if (SETUP_CYC == 8'd0) begin : g_bad_setup
    $error("SETUP_CYC must be in 1..255");
  end
  if (PULSE_CYC == 8'd0) begin : g_bad_pulse
    $error("PULSE_CYC must be in 1..255");
  end
  if (HOLD_CYC == 8'd0) begin : g_bad_hold
    $error("HOLD_CYC must be in 1..255");
  end
  if (CHK_CYC == 8'd0) begin : g_bad_chk
    $error("CHK_CYC must be in 1..255");
  end

  state_t     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic [1:0] op_q, op_d;
  logic       s_q, s_d;
  logic       r_q, r_d;
  logic       e_q, e_d;
  logic       done_q, done_d;
  logic [1:0] err_q, err_d;

`ifdef SR_SEQ_READBACK_EN
  logic q_prev_q, q_prev_d;
  logic exp_q;

  // Value Q should hold once the command has been applied.
  always_comb begin
    exp_q = q_prev_q;
    if (op_q == OP_SET) begin
      exp_q = 1'b1;
    end else if (op_q == OP_RESET) begin
      exp_q = 1'b0;
    end
  end
`else
  logic unused_readback;
  assign unused_readback = Q ^ Qbar;
`endif

  // Next-state and next-output logic for the command sequence.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    s_d     = s_q;
    r_d     = r_q;
    e_d     = e_q;
    done_d  = done_q;
    err_d   = err_q;
`ifdef SR_SEQ_READBACK_EN
    q_prev_d = q_prev_q;
`endif
    unique case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          op_d = req_op;
          if (req_op == OP_ILL) begin
            // done is raised one cycle later from DONE itself
            state_d = ST_DONE;
          end else begin
            s_d     = req_op[1];
            r_d     = req_op[0];
            cnt_d   = SETUP_CYC - 8'd1;
            state_d = ST_SETUP;
`ifdef SR_SEQ_READBACK_EN
            q_prev_d = Q;
`endif
          end
        end
      end
      ST_SETUP: begin
        if (cnt_q == '0) begin
          e_d     = 1'b1;
          cnt_d   = PULSE_CYC - 8'd1;
          state_d = ST_PULSE;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      ST_PULSE: begin
        if (cnt_q == '0) begin
          e_d     = 1'b0;
          cnt_d   = HOLD_CYC - 8'd1;
          state_d = ST_HOLD;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      ST_HOLD: begin
        if (cnt_q == '0) begin
          s_d = 1'b0;
          r_d = 1'b0;
`ifdef SR_SEQ_READBACK_EN
          cnt_d   = CHK_CYC - 8'd1;
          state_d = ST_CHECK;
`else
          done_d  = 1'b1;
          err_d   = 2'b00;
          state_d = ST_DONE;
`endif
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      ST_CHECK: begin
`ifdef SR_SEQ_READBACK_EN
        if (cnt_q == '0) begin
          done_d  = 1'b1;
          state_d = ST_DONE;
          if (Q == Qbar) begin
            err_d = 2'b11;
          end else if (Q != exp_q) begin
            err_d = 2'b10;
          end else begin
            err_d = 2'b00;
          end
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
`else
        state_d = ST_IDLE;
`endif
      end
      ST_DONE: begin
        // Entered with done already high except on the illegal-op path.
        if (!done_q) begin
          done_d = 1'b1;
          err_d  = 2'b01;
        end else begin
          done_d  = 1'b0;
          err_d   = 2'b00;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and registered outputs; reset abandons any command in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
      s_q     <= 1'b0;
      r_q     <= 1'b0;
      e_q     <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= '0;
`ifdef SR_SEQ_READBACK_EN
      q_prev_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      s_q     <= s_d;
      r_q     <= r_d;
      e_q     <= e_d;
      done_q  <= done_d;
      err_q   <= err_d;
`ifdef SR_SEQ_READBACK_EN
      q_prev_q <= q_prev_d;
`endif
    end
  end

  assign req_ready = (state_q == ST_IDLE);
  assign S         = s_q;
  assign R         = r_q;
  assign E         = e_q;
  assign done      = done_q;
  assign err_code  = err_q;

endmodule

// File: tb/tb_sr_latch_sequencer.sv
// Testbench for sr_latch_sequencer: directed table, hand-written corner
// sequences and random traffic checked against a timing-formula model.
module tb_sr_latch_sequencer;

  localparam int SETUP = 2;
  localparam int PULSE = 3;
  localparam int HOLD  = 1;
  localparam int CHK   = 2;
`ifdef SR_SEQ_READBACK_EN
  localparam bit RB = 1'b1;
`else
  localparam bit RB = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       req_valid;
  logic [1:0] req_op;
  logic       req_ready;
  logic       S, R, E;
  logic       Q, Qbar;
  logic       done;
  logic [1:0] err_code;

  sr_latch_sequencer #(
    .SETUP_CYC(8'(SETUP)),
    .PULSE_CYC(8'(PULSE)),
    .HOLD_CYC (8'(HOLD)),
    .CHK_CYC  (8'(CHK))
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .req_valid(req_valid),
    .req_op   (req_op),
    .req_ready(req_ready),
    .S        (S),
    .R        (R),
    .E        (E),
    .Q        (Q),
    .Qbar     (Qbar),
    .done     (done),
    .err_code (err_code)
  );

  always #5 clk = ~clk;

  // Behavioural gated SR latch with injectable faults:
  // fault 1 = Q stuck at 0, fault 2 = Q and Qbar both 1.
  int   fault = 0;
  logic lq = 1'b0;
  always @* begin
    if (E) begin
      if (S) lq = 1'b1;
      else if (R) lq = 1'b0;
    end
  end
  assign Q    = (fault == 1) ? 1'b0 : (fault == 2) ? 1'b1 : lq;
  assign Qbar = (fault == 2) ? 1'b1 : ~Q;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: one command at a time, outputs derived from distance to accept edge.
  int         m = 0;       // rising edges since reset release
  int         k = 0;       // edge that accepted the current command
  bit         active = 0;
  logic [1:0] mop = '0;
  int         mfault = 0;
  logic       e_prev = 1'b0;
  logic [1:0] sr_prev = '0;

  function automatic int done_dist(input logic [1:0] op);
    if (op == 2'b11) return 1;
    return SETUP + PULSE + HOLD + (RB ? CHK : 0);
  endfunction

  function automatic bit model_idle();
    return !active || ((m - k) > done_dist(mop));
  endfunction

  function automatic logic [1:0] model_err();
    if (mop == 2'b11) return 2'b01;
    if (!RB) return 2'b00;
    if (mfault == 2) return 2'b11;
    if (mfault == 1 && mop == 2'b10) return 2'b10;
    return 2'b00;
  endfunction

  task automatic compare_all();
    int   d;
    logic es, er, ee, ed, erdy;
    logic [1:0] eerr;
    d = m - k;
    es = 0; er = 0; ee = 0; ed = 0; erdy = 1; eerr = 2'b00;
    if (!model_idle()) begin
      erdy = 0;
      if (mop != 2'b11) begin
        es = (mop == 2'b10) && (d < SETUP + PULSE + HOLD);
        er = (mop == 2'b01) && (d < SETUP + PULSE + HOLD);
        ee = (d >= SETUP) && (d < SETUP + PULSE);
      end
      ed = (d == done_dist(mop));
      if (ed) eerr = model_err();
    end
    chk("S", 8'(S), 8'(es));
    chk("R", 8'(R), 8'(er));
    chk("E", 8'(E), 8'(ee));
    chk("done", 8'(done), 8'(ed));
    chk("err_code", 8'(err_code), 8'(eerr));
    chk("req_ready", 8'(req_ready), 8'(erdy));
    chk("inv_s_and_r", 8'(S & R), 8'd0);
    if (e_prev && E) chk("inv_sr_stable_while_e", 8'({S, R}), 8'(sr_prev));
    if (e_prev != E) chk("inv_sr_stable_at_e_edge", 8'({S, R}), 8'(sr_prev));
    e_prev  = E;
    sr_prev = {S, R};
  endtask

  // One clock: drive inputs, let the model see the edge, check at negedge.
  task automatic cycle(input bit v, input logic [1:0] op);
    bit rdy_m;
    req_valid = v;
    req_op    = op;
    rdy_m     = model_idle();
    @(posedge clk);
    m++;
    if (rdy_m && v) begin
      k = m; mop = op; active = 1; mfault = fault;
    end
    @(negedge clk);
    compare_all();
  endtask

  typedef struct {
    logic [1:0] op;
    int         flt;
    logic [1:0] err;
  } vec_t;

  task automatic run_cmd(input vec_t v);
    bit         seen = 0;
    logic [1:0] got = '0;
    int         n = 0;
    fault = v.flt;
    cycle(1'b1, v.op);
    while (!model_idle() && n < 600) begin
      cycle(1'b0, 2'b00);
      if (done) begin seen = 1; got = err_code; end
      n++;
    end
    chk("tbl_timeout", 8'(n < 600), 8'd1);
    chk("tbl_done_seen", 8'(seen), 8'd1);
    chk("tbl_err", 8'(got), 8'(v.err));
    fault = 0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req_valid = 1'b0;
    #1;
    chk("rst_S", 8'(S), 8'd0);
    chk("rst_R", 8'(R), 8'd0);
    chk("rst_E", 8'(E), 8'd0);
    chk("rst_done", 8'(done), 8'd0);
    chk("rst_err", 8'(err_code), 8'd0);
    chk("rst_ready", 8'(req_ready), 8'd1);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    active = 0; m = 0; k = 0;
    e_prev = 1'b0; sr_prev = '0;
  endtask

  vec_t       tbl[$];
  logic [1:0] alt[4];

  initial begin
    rst = 1'b1;
    req_valid = 1'b0;
    req_op = 2'b00;
    @(negedge clk);
    do_reset();

    // Directed command table: set, reset, hold, illegal, plus readback faults.
    tbl.push_back('{op: 2'b10, flt: 0, err: 2'b00});
    tbl.push_back('{op: 2'b01, flt: 0, err: 2'b00});
    tbl.push_back('{op: 2'b00, flt: 0, err: 2'b00});
    tbl.push_back('{op: 2'b11, flt: 0, err: 2'b01});
    tbl.push_back('{op: 2'b10, flt: 0, err: 2'b00});
    if (RB) begin
      tbl.push_back('{op: 2'b01, flt: 0, err: 2'b00});
      tbl.push_back('{op: 2'b10, flt: 1, err: 2'b10});
      tbl.push_back('{op: 2'b01, flt: 2, err: 2'b11});
      tbl.push_back('{op: 2'b00, flt: 0, err: 2'b00});
    end
    foreach (tbl[i]) run_cmd(tbl[i]);

    // Reset while E is high: outputs drop at once, no done, then recover.
    cycle(1'b1, 2'b10);
    while ((m - k) < SETUP) cycle(1'b0, 2'b00);
    chk("pre_rst_E_high", 8'(E), 8'd1);
    do_reset();
    for (int i = 0; i < 4; i++) cycle(1'b0, 2'b00);
    run_cmd('{op: 2'b01, flt: 0, err: 2'b00});

    // req_valid held high with alternating ops.
    alt[0] = 2'b10; alt[1] = 2'b01; alt[2] = 2'b00; alt[3] = 2'b11;
    for (int i = 0; i < 80; i++) cycle(1'b1, alt[(i / 3) % 4]);

    // Random traffic, no faults.
    for (int i = 0; i < 1500; i++)
      cycle(($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)));

    req_valid = 1'b0;
    for (int i = 0; i < 20; i++) cycle(1'b0, 2'b00);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
